// File: rtl/fft_seq_if.sv
// Handshake and data buses between the frame sequencer, the UART side and fft_top.
// The slave modport is the sequencer; the master modport is its environment.
interface fft_seq_if #(
  parameter int DATA_W     = 16,
  parameter int MAX_POINTS = 32,
  parameter int SEL_W      = 2
);
  logic                         rx_finished_i;
  logic [SEL_W-1:0]             fft_select_i;
  logic                         sample_valid_i;
  logic [DATA_W-1:0]            sample_R_i, sample_I_i;
  logic [MAX_POINTS*DATA_W-1:0] x_R_o, x_I_o;
  logic [SEL_W-1:0]             fft_select_o;
  logic                         fft_start_o;
  logic                         fft_valid_i;
  logic [MAX_POINTS*DATA_W-1:0] X_R_i, X_I_i;
  logic                         coef_valid_o, coef_ready_i;
  logic [DATA_W-1:0]            coef_R_o, coef_I_o;
  logic                         coef_last_o, busy_o, frame_err_o;

  modport slave (
    input  rx_finished_i, fft_select_i, sample_valid_i, sample_R_i, sample_I_i,
           fft_valid_i, X_R_i, X_I_i, coef_ready_i,
    output x_R_o, x_I_o, fft_select_o, fft_start_o, coef_valid_o, coef_R_o,
           coef_I_o, coef_last_o, busy_o, frame_err_o
  );

  modport master (
    output rx_finished_i, fft_select_i, sample_valid_i, sample_R_i, sample_I_i,
           fft_valid_i, X_R_i, X_I_i, coef_ready_i,
    input  x_R_o, x_I_o, fft_select_o, fft_start_o, coef_valid_o, coef_R_o,
           coef_I_o, coef_last_o, busy_o, frame_err_o
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller: collects N samples, launches the FFT, captures the result
// and streams N coefficients out over valid/ready.
module fft_frame_sequencer #(
  parameter int DATA_W     = 16,
  parameter int MAX_POINTS = 32,
  parameter int SEL_W      = 2
) (
  input logic      clk,
  input logic      rst,
  fft_seq_if.slave bus
);
  localparam int IW = $clog2(MAX_POINTS) + 1;
  localparam int AW = IW - 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, SEND} state_e;
  typedef logic [MAX_POINTS-1:0][DATA_W-1:0] buf_t;

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [IW-1:0]    idx_q, last_idx;
  buf_t             smp_r_q, smp_i_q, res_r_q, res_i_q;
  logic             start_q, cvalid_q, err_q;

  // Codes above 2 and sizes larger than the buffer are both reserved.
  function automatic logic legal(input logic [SEL_W-1:0] s);
    return (int'(s) < 3) && ((32'd8 << s) <= 32'(MAX_POINTS));
  endfunction

  always_comb last_idx = IW'((32'd8 << sel_q) - 32'd1);

  assign bus.x_R_o        = smp_r_q;
  assign bus.x_I_o        = smp_i_q;
  assign bus.fft_select_o = sel_q;
  assign bus.fft_start_o  = start_q;
  assign bus.coef_valid_o = cvalid_q;
  assign bus.coef_R_o     = cvalid_q ? res_r_q[idx_q[AW-1:0]] : '0;
  assign bus.coef_I_o     = cvalid_q ? res_i_q[idx_q[AW-1:0]] : '0;
  assign bus.coef_last_o  = cvalid_q && (idx_q == last_idx);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.frame_err_o  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      smp_r_q  <= '0;
      smp_i_q  <= '0;
      res_r_q  <= '0;
      res_i_q  <= '0;
      start_q  <= 1'b0;
      cvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.rx_finished_i) begin
          if (legal(bus.fft_select_i)) begin
            sel_q   <= bus.fft_select_i;
            smp_r_q <= '0;
            smp_i_q <= '0;
            idx_q   <= '0;
            state_q <= LOAD;
          end else begin
            err_q <= 1'b1;
          end
        end
        LOAD: begin
          // A new header mid-frame wins over any simultaneous sample.
          if (bus.rx_finished_i) begin
            err_q <= 1'b1;
            if (legal(bus.fft_select_i)) begin
              sel_q   <= bus.fft_select_i;
              smp_r_q <= '0;
              smp_i_q <= '0;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (bus.sample_valid_i) begin
            smp_r_q[idx_q[AW-1:0]] <= bus.sample_R_i;
            smp_i_q[idx_q[AW-1:0]] <= bus.sample_I_i;
            if (idx_q == last_idx) begin
              start_q <= 1'b1;
              state_q <= START;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        START: state_q <= RUN;
        RUN: begin
          if (bus.sample_valid_i || bus.rx_finished_i) err_q <= 1'b1;
          if (bus.fft_valid_i) begin
            res_r_q  <= bus.X_R_i;
            res_i_q  <= bus.X_I_i;
            idx_q    <= '0;
            cvalid_q <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (bus.sample_valid_i || bus.rx_finished_i) err_q <= 1'b1;
          if (bus.coef_ready_i) begin
            if (idx_q == last_idx) begin
              cvalid_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scenario bench for fft_frame_sequencer: expected coefficients are queued when
// the FFT result is driven and popped as the DUT hands them over.
module tb_fft_frame_sequencer;
  localparam int DW = 16;
  localparam int MP = 32;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic          last;
  } coef_t;

  logic clk, rst;
  int   checks, passed;
  coef_t sb[$];

  fft_seq_if #(.DATA_W(DW), .MAX_POINTS(MP), .SEL_W(2)) bus ();
  fft_frame_sequencer #(.DATA_W(DW), .MAX_POINTS(MP), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic pulse_rx(input logic [1:0] s);
    bus.rx_finished_i = 1'b1; bus.fft_select_i = s;
    @(posedge clk); #1;
    bus.rx_finished_i = 1'b0;
  endtask

  task automatic push_sample(input logic [DW-1:0] r, input logic [DW-1:0] i);
    bus.sample_valid_i = 1'b1; bus.sample_R_i = r; bus.sample_I_i = i;
    @(posedge clk); #1;
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic fft_pulse(input logic [MP*DW-1:0] xr, input logic [MP*DW-1:0] xi);
    bus.X_R_i = xr; bus.X_I_i = xi; bus.fft_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.fft_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy_o, bus.coef_valid_o, bus.fft_start_o, bus.frame_err_o, bus.coef_last_o} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {bus.busy_o, bus.coef_valid_o, bus.fft_start_o, bus.frame_err_o, bus.coef_last_o});
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.x_R_o, bus.x_I_o, bus.coef_R_o, bus.coef_I_o, bus.fft_select_o, bus.busy_o} !== '0)
      $display("FAIL reset_data got nonzero busy=%b sel=%0d coefR=%h", bus.busy_o, bus.fft_select_o, bus.coef_R_o);
    else passed++;
  endtask

  task automatic test_basic8();
    int extra;
    logic [DW-1:0] er, ei;
    pulse_rx(2'd0);
    checks++;
    if ({bus.busy_o, bus.fft_select_o} !== 3'b100)
      $display("FAIL b8_load got busy=%b sel=%0d want busy=1 sel=0", bus.busy_o, bus.fft_select_o);
    else passed++;
    for (int k = 0; k < 8; k++) push_sample(DW'(k + 1), DW'(-(k + 1)));
    checks++;
    if (bus.fft_start_o !== 1'b1) $display("FAIL b8_start got %b want 1", bus.fft_start_o);
    else passed++;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.fft_start_o) extra++;
    end
    checks++;
    if (extra != 0) $display("FAIL b8_start_once got %0d extra pulses want 0", extra);
    else passed++;
    for (int k = 0; k < MP; k++) begin
      er = (k < 8) ? DW'(k + 1) : '0;
      ei = (k < 8) ? DW'(-(k + 1)) : '0;
      checks++;
      if ({bus.x_R_o[k*DW +: DW], bus.x_I_o[k*DW +: DW]} !== {er, ei})
        $display("FAIL b8_x[%0d] got %h/%h want %h/%h", k, bus.x_R_o[k*DW +: DW], bus.x_I_o[k*DW +: DW], er, ei);
      else passed++;
    end
    // Abandon the frame while waiting in RUN.
    rst = 1'b1; #1;
    checks++;
    if ({bus.busy_o, bus.fft_start_o, bus.coef_valid_o, (|bus.x_R_o)} !== 4'b0)
      $display("FAIL b8_rst_run got busy=%b start=%b cv=%b xnz=%b", bus.busy_o, bus.fft_start_o, bus.coef_valid_o, |bus.x_R_o);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    pulse_rx(2'd1);
    for (int k = 0; k < 3; k++) push_sample(DW'(7 + k), DW'(k));
    checks++;
    if (bus.x_R_o[2*DW +: DW] !== DW'(9)) $display("FAIL ml_loaded got %h want 0009", bus.x_R_o[2*DW +: DW]);
    else passed++;
    rst = 1'b1; #1;
    checks++;
    if ({bus.busy_o, (|bus.x_R_o), (|bus.x_I_o)} !== 3'b0)
      $display("FAIL ml_rst got busy=%b xRnz=%b xInz=%b want 000", bus.busy_o, |bus.x_R_o, |bus.x_I_o);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full32();
    logic [MP*DW-1:0] xr, xi;
    coef_t e;
    int got, cyc;
    pulse_rx(2'd2);
    checks++;
    if ({bus.busy_o, bus.fft_select_o} !== 3'b110)
      $display("FAIL f32_load got busy=%b sel=%0d want busy=1 sel=2", bus.busy_o, bus.fft_select_o);
    else passed++;
    for (int k = 0; k < MP; k++) push_sample(DW'(k * 3), DW'(k));
    checks++;
    if (bus.fft_start_o !== 1'b1) $display("FAIL f32_start got %b want 1", bus.fft_start_o);
    else passed++;
    @(posedge clk); #1;
    for (int k = 0; k < MP; k++) begin
      xr[k*DW +: DW] = DW'(100 + k);
      xi[k*DW +: DW] = DW'(k);
      sb.push_back('{r: DW'(100 + k), i: DW'(k), last: (k == MP - 1)});
    end
    fft_pulse(xr, xi);
    checks++;
    if (bus.coef_valid_o !== 1'b1) $display("FAIL f32_cv_latency got %b want 1", bus.coef_valid_o);
    else passed++;
    got = 0; cyc = 0;
    bus.coef_ready_i = 1'b1;
    while (got < MP && cyc < 200) begin
      if (bus.coef_valid_o) begin
        e = sb.pop_front();
        checks++;
        if ({bus.coef_R_o, bus.coef_I_o, bus.coef_last_o} !== e)
          $display("FAIL f32_coef[%0d] got %h/%h/%b want %h/%h/%b", got, bus.coef_R_o, bus.coef_I_o, bus.coef_last_o, e.r, e.i, e.last);
        else passed++;
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.coef_ready_i = 1'b0;
    checks++;
    if (got != MP) $display("FAIL f32_timeout got %0d coefs want %0d", got, MP);
    else passed++;
    checks++;
    if ({bus.coef_valid_o, bus.busy_o} !== 2'b00)
      $display("FAIL f32_idle got cv=%b busy=%b want 00", bus.coef_valid_o, bus.busy_o);
    else passed++;
  endtask

  task automatic test_stall16();
    logic [MP*DW-1:0] xr, xi;
    coef_t e, prev;
    logic held;
    int got, cyc, ph;
    // Issued in the first IDLE cycle after the previous frame.
    pulse_rx(2'd1);
    checks++;
    if ({bus.busy_o, bus.fft_select_o} !== 3'b101)
      $display("FAIL s16_b2b got busy=%b sel=%0d want busy=1 sel=1", bus.busy_o, bus.fft_select_o);
    else passed++;
    for (int k = 0; k < 16; k++) push_sample(DW'(k), DW'(~k));
    @(posedge clk); #1;
    for (int k = 0; k < MP; k++) begin
      xr[k*DW +: DW] = DW'(200 + k);
      xi[k*DW +: DW] = DW'(k * 5);
      if (k < 16) sb.push_back('{r: DW'(200 + k), i: DW'(k * 5), last: (k == 15)});
    end
    fft_pulse(xr, xi);
    got = 0; cyc = 0; ph = 0; held = 1'b0; prev = '0;
    while (got < 16 && cyc < 400) begin
      bus.coef_ready_i = (ph == 0);
      if (held) begin
        checks++;
        if ({bus.coef_valid_o, bus.coef_R_o, bus.coef_I_o, bus.coef_last_o} !== {1'b1, prev})
          $display("FAIL s16_hold got cv=%b %h/%h/%b want 1 %h/%h/%b", bus.coef_valid_o, bus.coef_R_o, bus.coef_I_o, bus.coef_last_o, prev.r, prev.i, prev.last);
        else passed++;
      end
      held = 1'b0;
      if (bus.coef_valid_o) begin
        if (bus.coef_ready_i) begin
          e = sb.pop_front();
          checks++;
          if ({bus.coef_R_o, bus.coef_I_o, bus.coef_last_o} !== e)
            $display("FAIL s16_coef[%0d] got %h/%h/%b want %h/%h/%b", got, bus.coef_R_o, bus.coef_I_o, bus.coef_last_o, e.r, e.i, e.last);
          else passed++;
          got++;
        end else begin
          held = 1'b1;
          prev = {bus.coef_R_o, bus.coef_I_o, bus.coef_last_o};
        end
      end
      @(posedge clk); #1; cyc++; ph = (ph + 1) % 3;
    end
    bus.coef_ready_i = 1'b0;
    checks++;
    if (got != 16) $display("FAIL s16_timeout got %0d coefs want 16", got);
    else passed++;
    checks++;
    if ({bus.coef_valid_o, bus.busy_o} !== 2'b00)
      $display("FAIL s16_idle got cv=%b busy=%b want 00", bus.coef_valid_o, bus.busy_o);
    else passed++;
  endtask

  task automatic test_errors();
    logic [MP*DW-1:0] xr, xi;
    coef_t e;
    int got, cyc;
    pulse_rx(2'd3);
    checks++;
    if ({bus.frame_err_o, bus.busy_o} !== 2'b10)
      $display("FAIL err_rsv got err=%b busy=%b want 10", bus.frame_err_o, bus.busy_o);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (bus.frame_err_o !== 1'b0) $display("FAIL err_rsv_once got %b want 0", bus.frame_err_o);
    else passed++;
    pulse_rx(2'd1);
    for (int k = 0; k < 5; k++) push_sample(DW'(16'h0f00 + k), DW'(k));
    pulse_rx(2'd0);
    checks++;
    if ({bus.frame_err_o, bus.busy_o, bus.fft_select_o, (|bus.x_R_o)} !== 5'b11000)
      $display("FAIL err_restart got err=%b busy=%b sel=%0d xnz=%b want 1 1 0 0", bus.frame_err_o, bus.busy_o, bus.fft_select_o, |bus.x_R_o);
    else passed++;
    for (int k = 0; k < 8; k++) push_sample(DW'(50 + k), DW'(k));
    @(posedge clk); #1;
    push_sample(16'hdead, 16'hbeef);
    checks++;
    if ({bus.frame_err_o, bus.x_R_o[0 +: DW], bus.x_R_o[8*DW +: DW]} !== {1'b1, DW'(50), DW'(0)})
      $display("FAIL err_run got err=%b x0=%h x8=%h want 1 0032 0000", bus.frame_err_o, bus.x_R_o[0 +: DW], bus.x_R_o[8*DW +: DW]);
    else passed++;
    for (int k = 0; k < MP; k++) begin
      xr[k*DW +: DW] = DW'(k * 7);
      xi[k*DW +: DW] = DW'(-k);
      if (k < 8) sb.push_back('{r: DW'(k * 7), i: DW'(-k), last: (k == 7)});
    end
    fft_pulse(xr, xi);
    push_sample(16'h1234, 16'h5678);
    checks++;
    if ({bus.frame_err_o, bus.coef_valid_o, bus.coef_R_o} !== {2'b11, DW'(0)})
      $display("FAIL err_send got err=%b cv=%b coefR=%h want 1 1 0000", bus.frame_err_o, bus.coef_valid_o, bus.coef_R_o);
    else passed++;
    got = 0; cyc = 0;
    bus.coef_ready_i = 1'b1;
    while (got < 8 && cyc < 100) begin
      if (bus.coef_valid_o) begin
        e = sb.pop_front();
        checks++;
        if ({bus.coef_R_o, bus.coef_I_o, bus.coef_last_o} !== e)
          $display("FAIL err_coef[%0d] got %h/%h/%b want %h/%h/%b", got, bus.coef_R_o, bus.coef_I_o, bus.coef_last_o, e.r, e.i, e.last);
        else passed++;
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.coef_ready_i = 1'b0;
    checks++;
    if ({got == 8, bus.busy_o, bus.coef_valid_o} !== 3'b100)
      $display("FAIL err_done got coefs=%0d busy=%b cv=%b want 8 0 0", got, bus.busy_o, bus.coef_valid_o);
    else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    rst = 1'b1;
    bus.rx_finished_i = 1'b0; bus.fft_select_i = '0;
    bus.sample_valid_i = 1'b0; bus.sample_R_i = '0; bus.sample_I_i = '0;
    bus.fft_valid_i = 1'b0; bus.X_R_i = '0; bus.X_I_i = '0;
    bus.coef_ready_i = 1'b0;
    test_reset();
    test_basic8();
    test_reset_mid_load();
    test_full32();
    test_stall16();
    test_errors();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
